// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one 16/8 divider (start/done) among NREQ requesters.
// Optional macro DIV_CHECK_EN screens divide-by-zero/overflow and answers without using the divider.
module div_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_dividend,
  input  logic [8*NREQ-1:0]    req_divisor,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [7:0]           rsp_quotient,
  output logic [7:0]           rsp_remainder,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 div_start,
  output logic [15:0]          div_dividend,
  output logic [7:0]           div_divisor,
  input  logic [7:0]           div_quotient,
  input  logic [7:0]           div_remainder,
  input  logic                 div_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] sel;
  logic          sel_any;
  logic [15:0]   sel_dividend;
  logic [7:0]    sel_divisor;
  logic          sel_flag;
  int unsigned   idx;

  // Offsets are scanned farthest-first so the nearest requester after ptr wins.
  always_comb begin
    sel     = '0;
    sel_any = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + NREQ - k) % NREQ;
      if (req_valid[PW'(idx)]) begin
        sel     = PW'(idx);
        sel_any = 1'b1;
      end
    end
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (sel == PW'(k)) begin
        sel_dividend = req_dividend[16*k +: 16];
        sel_divisor  = req_divisor[8*k +: 8];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == S_IDLE && sel_any)
      req_ready[sel] = 1'b1;
  end

`ifdef DIV_CHECK_EN
  logic err_q;
  // Quotient overflows 8 bits exactly when the dividend's high byte reaches the divisor.
  assign sel_flag = (sel_divisor == 8'd0) || (sel_dividend[15:8] >= sel_divisor);
  assign rsp_err  = err_q;
`else
  assign sel_flag = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ptr           <= PW'(NREQ - 1);
      gnt           <= '0;
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      busy          <= 1'b0;
      div_start     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
`ifdef DIV_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_any) begin
            gnt          <= sel;
            ptr          <= sel;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            busy         <= 1'b1;
            if (sel_flag) begin
              rsp_quotient  <= 8'hFF;
              rsp_remainder <= 8'h00;
`ifdef DIV_CHECK_EN
              err_q         <= 1'b1;
`endif
              rsp_valid     <= NREQ'(1) << sel;
              state         <= S_RESP;
            end else begin
              div_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
`ifdef DIV_CHECK_EN
            err_q         <= 1'b0;
`endif
            rsp_valid     <= NREQ'(1) << gnt;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural 19-cycle divider stand-in.
// Expectations follow DIV_CHECK_EN when the macro is defined for the build.
module tb_div_arbiter;
  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [16*NREQ-1:0]  req_dividend;
  logic [8*NREQ-1:0]   req_divisor;
  logic [7:0]          rsp_quotient, rsp_remainder, div_divisor, div_quotient, div_remainder;
  logic                rsp_err, busy, div_start, div_done, model_done, spur_done;
  logic [15:0]         div_dividend, div_res;
  logic [15:0]         op_a [NREQ];
  logic [7:0]          op_b [NREQ];
  int                  cyc = 0, checks = 0, fails = 0, last = NREQ - 1, dcnt;

  div_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .busy(busy), .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] raw_div(input logic [15:0] a, input logic [7:0] b);
    if (b == 8'd0) return {8'hFF, a[7:0]};
    return {8'(a / {8'd0, b}), 8'(a % {8'd0, b})};
  endfunction

  // {err, quotient, remainder} the arbiter should report for one request
  function automatic logic [16:0] exp_res(input logic [15:0] a, input logic [7:0] b);
`ifdef DIV_CHECK_EN
    if (b == 8'd0 || (a / 256) >= b) return {1'b1, 8'hFF, 8'h00};
`endif
    return {1'b0, raw_div(a, b)};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    return 0;
  endfunction

  // Divider stand-in: done pulses in the 19th cycle after the start cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= 0; model_done <= 1'b0; div_res <= '0;
      div_quotient <= '0; div_remainder <= '0;
    end else begin
      model_done <= 1'b0;
      if (div_start) begin
        dcnt    <= 18;
        div_res <= raw_div(div_dividend, div_divisor);
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) begin
          model_done    <= 1'b1;
          div_quotient  <= div_res[15:8];
          div_remainder <= div_res[7:0];
        end
      end
    end
  end
  assign div_done = model_done | spur_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ops(input int r, input logic [15:0] a, input logic [7:0] b);
    op_a[r] = a; op_b[r] = b;
    req_dividend[16*r +: 16] = a;
    req_divisor[8*r +: 8]    = b;
  endtask

  // Offer mask, follow one transaction to completion, hold the response for hold cycles.
  task automatic serve(input logic [NREQ-1:0] mask, input int hold, input logic [7:0] eq,
                       input logic [7:0] er, input logic ee, output int got);
    int g, n, e0, starts, start_cyc, bad;
    logic [15:0] data;
    g = rr_pick(mask);
    got = -1;
    req_valid = mask; rsp_ready = '0;
    #1;
    n = 0;
    while (req_ready == '0 && n < 10) begin @(negedge clk); #1; n++; end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) got = i;
    chk("grant", req_ready, NREQ'(1) << g);
    e0 = cyc + 1;
    @(negedge clk);
    req_valid = '0;
    starts = 0; start_cyc = 0; bad = 0; n = 0;
    while (rsp_valid == '0 && n < 60) begin
      if (div_start) begin starts++; start_cyc = cyc; end
      if (req_ready != '0 || !busy) bad++;
      @(negedge clk); n++;
    end
    chk("rsp_latency", cyc - e0 + 1, ee ? 1 : 21);
    chk("rsp_valid", rsp_valid, NREQ'(1) << g);
    chk("quotient", rsp_quotient, eq);
    chk("remainder", rsp_remainder, er);
    chk("rsp_err", rsp_err, ee);
    chk("start_pulses", starts, ee ? 0 : 1);
    if (!ee) chk("start_latency", start_cyc - e0 + 1, 1);
    chk("busy_no_ready", bad, 0);
    data = {rsp_quotient, rsp_remainder};
    bad = 0;
    rsp_ready = ~(NREQ'(1) << g);
    req_valid = mask;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid != (NREQ'(1) << g) || {rsp_quotient, rsp_remainder} != data ||
          !busy || req_ready != '0) bad++;
    end
    if (hold > 0) chk("backpressure_hold", bad, 0);
    rsp_ready = '1;
    #1 chk("no_accept_in_resp", req_ready, 0);
    last = g;
    @(negedge clk); #1;
    chk("released", {busy, rsp_valid}, 0);
    chk("bubble_grant", req_ready, NREQ'(1) << rr_pick(mask));
    req_valid = '0; rsp_ready = '0;
  endtask

  typedef struct {
    int          r;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  rm;
    logic        flag;
  } vec_t;

  initial begin
    vec_t        tbl [8];
    int          got, n, g, order [5];
    logic [16:0] e;
    logic [NREQ-1:0] mask;

    tbl[0] = '{0, 16'd1000,  8'd7,   8'd142, 8'd6,   1'b0};
    tbl[1] = '{1, 16'h04FF,  8'd5,   8'd255, 8'd4,   1'b0};
    tbl[2] = '{2, 16'h0900,  8'h05,  8'd204, 8'd4,   1'b1};
    tbl[3] = '{3, 16'd50,    8'd0,   8'hFF,  8'h32,  1'b1};
    tbl[4] = '{0, 16'hFFFF,  8'hFF,  8'd1,   8'd0,   1'b1};
    tbl[5] = '{1, 16'd300,   8'd2,   8'd150, 8'd0,   1'b0};
    tbl[6] = '{2, 16'h0500,  8'h05,  8'd0,   8'd0,   1'b1};
    tbl[7] = '{3, 16'h00FF,  8'h01,  8'd255, 8'd0,   1'b0};
    order = '{0, 1, 2, 3, 0};

    req_valid = '1; rsp_ready = '0; spur_done = 1'b0;
    req_dividend = '0; req_divisor = '0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'd0, 8'd1);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, busy,
                          div_start, div_dividend, div_divisor}, 0);
    rst = 1'b0; req_valid = '0; last = NREQ - 1;

    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    #1 chk("spurious_done_ignored", {busy, rsp_valid, div_start}, 0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      set_ops(tbl[i].r, tbl[i].a, tbl[i].b);
`ifdef DIV_CHECK_EN
      if (tbl[i].flag) serve(NREQ'(1) << tbl[i].r, 0, 8'hFF, 8'h00, 1'b1, got);
      else             serve(NREQ'(1) << tbl[i].r, 0, tbl[i].q, tbl[i].rm, 1'b0, got);
`else
      serve(NREQ'(1) << tbl[i].r, 0, tbl[i].q, tbl[i].rm, 1'b0, got);
`endif
    end

    for (int i = 0; i < NREQ; i++) set_ops(i, 16'($urandom_range(0, 3000)), 8'($urandom_range(1, 255)));
    for (int i = 0; i < 5; i++) begin
      g = rr_pick('1);
      e = exp_res(op_a[g], op_b[g]);
      serve('1, 0, e[15:8], e[7:0], e[16], got);
      chk("rr_order", got, order[i]);
    end
    e = exp_res(op_a[2], op_b[2]);
    serve(4'b0100, 0, e[15:8], e[7:0], e[16], got);
    e = exp_res(op_a[0], op_b[0]);
    serve(4'b0101, 0, e[15:8], e[7:0], e[16], got);
    chk("rr_skip_to_0", got, 0);

    set_ops(1, 16'd1000, 8'd7);
    serve('1, 10, 8'd142, 8'd6, 1'b0, got);
    chk("backpressure_grant", got, 1);

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NREQ; i++)
        set_ops(i, $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 2000)),
                ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom));
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      g = rr_pick(mask);
      e = exp_res(op_a[g], op_b[g]);
      serve(mask, $urandom_range(0, 3), e[15:8], e[7:0], e[16], got);
    end

    for (int i = 0; i < NREQ; i++) set_ops(i, 16'd1000, 8'd7);
    req_valid = '1; #1;
    n = 0;
    while (req_ready == '0 && n < 10) begin @(negedge clk); #1; n++; end
    @(negedge clk); req_valid = '0;
    n = 0;
    while (!div_start && n < 10) begin @(negedge clk); n++; end
    chk("start_before_reset", div_start, 1);
    repeat (5) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    #1 rst = 1'b1; req_valid = '1;
    #1 chk("async_reset_outputs", {req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
                                   busy, div_start, div_dividend, div_divisor}, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0; last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      serve('1, 0, 8'd142, 8'd6, 1'b0, got);
      chk("post_reset_order", got, i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one 16/8 non-restoring divider (start/done pulse interface, 8-bit quotient and remainder) between NREQ requesters. It accepts one request at a time and drives the divider's operands and start pulse. It waits for the divider's done pulse, then returns the result to the granted requester with a valid/ready handshake. It sits between the ALU issue ports and the divider instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid; held until accepted
- req_ready  out  NREQ  one-hot accept; combinational; forced 0 while rst high
- req_dividend  in  16*NREQ  dividend of requester i at bits [16i+15:16i]
- req_divisor  in  8*NREQ  divisor of requester i at bits [8i+7:8i]
- rsp_valid  out  NREQ  one-hot response valid to the granted requester
- rsp_ready  in  NREQ  per-requester response accept
- rsp_quotient  out  8  shared result quotient
- rsp_remainder  out  8  shared result remainder
- rsp_err  out  1  divide-by-zero/overflow flag (see Configuration)
- busy  out  1  high in any state other than IDLE
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend  out  16  divider dividend, held stable from ISSUE through WAIT
- div_divisor  out  8  divider divisor, held stable from ISSUE through WAIT
- div_quotient  in  8  divider quotient
- div_remainder  in  8  divider remainder
- div_done  in  1  divider one-cycle done pulse

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant g = first set bit searching upward (with wrap) from ptr+1. req_ready[g]=1 this cycle. On the edge: latch operands and g, set ptr<=g.
  - Normal request: go to ISSUE.
  - Error-screened request: go to RESP (DIV_CHECK_EN only).
- ISSUE: div_start=1 for exactly one cycle -> WAIT.
- WAIT: on div_done, capture div_quotient/div_remainder into rsp registers, set rsp_err=0 -> RESP. Otherwise stay; no timeout.
- RESP: rsp_valid[g]=1, data held stable. When rsp_ready[g]=1 -> IDLE, rsp_valid cleared. rsp_ready of other requesters is ignored.
- ptr resets to NREQ-1, so requester 0 wins the first arbitration.
- Only one request is in flight. req_ready is 0 in ISSUE/WAIT/RESP.
- req_valid seen in IDLE the same cycle RESP completes is not accepted until the next cycle (one bubble).
- div_done outside WAIT is ignored.
- Reset values: all outputs 0, rsp registers 0, div_dividend/div_divisor 0, state IDLE, ptr NREQ-1.
- Reset mid-operation returns to IDLE immediately and discards the in-flight request. The divider shares rst.

## Timing
- Acceptance edge E0 (req_valid[g] & req_ready[g]). div_start is high in the cycle after E0.
- Normal-path latency is set by the divider: with the 8-iteration divider, div_done is seen 19 cycles after the div_start cycle, and rsp_valid rises 21 cycles after E0.
- Error path (DIV_CHECK_EN): rsp_valid rises 1 cycle after E0, and div_start never pulses.
- Minimum request-to-request spacing: RESP handshake cycle + 1 IDLE cycle.

## Configuration
- DIV_CHECK_EN defined:
  - In IDLE, the selected request is flagged if divisor==0 or dividend[15:8] >= divisor (quotient would not fit in 8 bits).
  - A flagged request bypasses the divider: rsp_quotient=8'hFF, rsp_remainder=8'h00, rsp_err=1.
- DIV_CHECK_EN undefined:
  - No screening; every request goes to the divider and rsp_err is tied 0.
  - Results for divisor 0 or overflowing operands are whatever the divider returns.

## Test plan
- Single request: req0 dividend 16'd1000, divisor 8'd7 -> div_start one cycle after E0; rsp_valid[0] at E0+21; quotient 142, remainder 6, rsp_err 0.
- Round-robin: req_valid=4'b1111 held, rsp_ready=all 1 -> grant order 0,1,2,3,0. Next: only req_valid[2] and [0] set after granting 2 -> grant 0.
- Back-pressure: rsp_ready[1]=0 for 10 cycles after rsp_valid[1] -> rsp_valid[1] and data stable; busy=1; no req_ready asserted; release -> IDLE next cycle.
- DIV_CHECK_EN, divisor 0 and dividend 16'h0900/divisor 8'h05 -> rsp_valid at E0+1, quotient FF, remainder 00, rsp_err 1, no div_start. Without macro the same stimulus reaches the divider with rsp_err 0.
- Reset in WAIT: assert rst 5 cycles after div_start -> all outputs 0 asynchronously. After release, a pending req3 wins only after req0..req2 if those are pending (ptr=NREQ-1).
